count_seg7_display: RTL

//  Downstream consumer of the 8-bit event counter's count bus. Converts the unsigned

---
 rtl/count_seg7_display.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/count_seg7_display.sv
// Converts an 8-bit binary count to three BCD digits with a sequential double-dabble FSM
// and scans them onto a 4-digit common-anode 7-segment display. Option: LEADING_ZERO_BLANK_EN.
module count_seg7_display #(
    parameter int DATA_WIDTH  = 8,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] value,
    output logic [3:0]            an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  busy,
    output logic [11:0]           bcd
);

    localparam int SR_W   = 12 + DATA_WIDTH;
    localparam int ITER_W = $clog2(DATA_WIDTH);
    localparam int CNT_W  = $clog2(REFRESH_DIV);

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_capture;
    logic [DATA_WIDTH-1:0] r_last_value;
    logic [11:0]           r_scratch;
    logic [ITER_W-1:0]     r_iter;
    logic                  r_busy;
    logic [11:0]           r_bcd;
    logic [CNT_W-1:0]      r_refresh_cnt;
    logic [1:0]            r_sel;
    logic [3:0]            r_an;
    logic [6:0]            r_seg;

    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] w_shift_nxt;
    logic [DATA_WIDTH-1:0] w_capture_nxt;
    logic [DATA_WIDTH-1:0] w_last_nxt;
    logic [11:0]           w_scratch_nxt;
    logic [ITER_W-1:0]     w_iter_nxt;
    logic                  w_busy_nxt;
    logic [11:0]           w_bcd_nxt;
    logic [SR_W-1:0]       w_shifted;
    logic [3:0]            w_nibble;
    logic                  w_blank;
    logic [3:0]            w_an_nxt;
    logic [6:0]            w_seg_nxt;

    function automatic logic [11:0] bcd_adjust(input logic [11:0] d);
        logic [11:0] r;
        r = d;
        for (int i = 0; i < 3; i++) begin
            if (d[4*i +: 4] >= 4'd5) r[4*i +: 4] = d[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    assign w_shifted = {bcd_adjust(r_scratch), r_shift} << 1;

    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_capture_nxt = r_capture;
        w_last_nxt    = r_last_value;
        w_scratch_nxt = r_scratch;
        w_iter_nxt    = r_iter;
        w_busy_nxt    = r_busy;
        w_bcd_nxt     = r_bcd;
        case (r_state)
            S_IDLE: begin
                if (value != r_last_value) begin
                    w_shift_nxt   = value;
                    w_capture_nxt = value;
                    w_scratch_nxt = '0;
                    w_iter_nxt    = '0;
                    w_busy_nxt    = 1'b1;
                    w_state_nxt   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_shift_nxt   = w_shifted[DATA_WIDTH-1:0];
                w_scratch_nxt = w_shifted[SR_W-1:DATA_WIDTH];
                w_iter_nxt    = r_iter + 1'b1;
                // The last shift commits straight from the shifter output.
                if (r_iter == ITER_W'(DATA_WIDTH - 1)) begin
                    w_bcd_nxt   = w_shifted[SR_W-1:DATA_WIDTH];
                    w_last_nxt  = r_capture;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        case (r_sel)
            2'd1:    w_nibble = r_bcd[7:4];
            2'd2:    w_nibble = r_bcd[11:8];
            default: w_nibble = r_bcd[3:0];
        endcase
        w_blank = (r_sel == 2'd3);
`ifdef LEADING_ZERO_BLANK_EN
        if (r_sel == 2'd2 && r_bcd[11:8] == 4'd0) w_blank = 1'b1;
        if (r_sel == 2'd1 && r_bcd[11:4] == 8'd0) w_blank = 1'b1;
`endif
        w_an_nxt  = ~(4'b0001 << r_sel);
        w_seg_nxt = w_blank ? 7'b1111111 : seg_decode(w_nibble);
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_shift       <= '0;
            r_capture     <= '0;
            r_last_value  <= '0;
            r_scratch     <= '0;
            r_iter        <= '0;
            r_busy        <= 1'b0;
            r_bcd         <= '0;
            r_refresh_cnt <= '0;
            r_sel         <= '0;
            r_an          <= 4'b1111;
            r_seg         <= 7'b1111111;
        end else begin
            r_state      <= w_state_nxt;
            r_shift      <= w_shift_nxt;
            r_capture    <= w_capture_nxt;
            r_last_value <= w_last_nxt;
            r_scratch    <= w_scratch_nxt;
            r_iter       <= w_iter_nxt;
            r_busy       <= w_busy_nxt;
            r_bcd        <= w_bcd_nxt;
            r_an         <= w_an_nxt;
            r_seg        <= w_seg_nxt;
            if (r_refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
                r_refresh_cnt <= '0;
                r_sel         <= r_sel + 2'd1;
            end else begin
                r_refresh_cnt <= r_refresh_cnt + 1'b1;
            end
        end
    end

    assign an   = r_an;
    assign seg  = r_seg;
    assign dp   = 1'b1;
    assign busy = r_busy;
    assign bcd  = r_bcd;

endmodule
